// File: rtl/mem_port_arbiter.sv
// Arbitrates the single RAMHelper port between IF (read-only) and MEM (load/store) requesters.
// MEM has priority. A starvation counter forces an IF grant. The response follows one cycle later.
module mem_port_arbiter #(
  parameter int unsigned DATA_W     = 64,
  parameter logic [63:0] BASE       = 64'h8000_0000,
  parameter int unsigned SIZE_LOG2  = 27,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [63:0]       if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              mem_req_valid,
  input  logic              mem_req_wen,
  input  logic [63:0]       mem_req_addr,
  input  logic [DATA_W-1:0] mem_req_wdata,
  input  logic [DATA_W-1:0] mem_req_wmask,
  output logic              mem_req_ready,
  output logic              mem_rsp_valid,
  output logic [DATA_W-1:0] mem_rsp_data,
  output logic              mem_rsp_err,
  output logic              ram_en,
  output logic [63:0]       ram_ridx,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_wen,
  output logic [63:0]       ram_widx,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] ram_wmask
);

  localparam int unsigned CntW     = $clog2(STARVE_MAX + 1);
  localparam logic [63:0] RamBytes = 64'd1 << SIZE_LOG2;

  typedef enum logic [1:0] {StIdle, StRspIf, StRspMem} state_e;

  state_e            state_q;
  logic [CntW-1:0]   starve_cnt_q;
  logic [DATA_W-1:0] if_data_q, mem_data_q;
  logic              if_err_q, mem_err_q;

  logic              grant_if, grant_mem, access, in_range, sel_wen;
  logic [63:0]       sel_addr, offset, idx;
  logic [DATA_W-1:0] rsp_data_d;

  // Grants are suppressed while reset is held so every output reads 0.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (reset) begin
      if (starve_cnt_q == CntW'(STARVE_MAX) && if_req_valid) grant_if = 1'b1;
      else if (mem_req_valid)                               grant_mem = 1'b1;
      else if (if_req_valid)                                grant_if = 1'b1;
    end
  end

  always_comb begin
    sel_addr = grant_mem ? mem_req_addr : if_req_addr;
    sel_wen  = grant_mem & mem_req_wen;
    offset   = sel_addr - BASE;
    // Compare the offset rather than BASE + size so the upper bound cannot overflow.
    in_range = (sel_addr >= BASE) && (offset < RamBytes);
    idx      = offset >> 3;
    access   = (grant_if | grant_mem) & in_range;
  end

  always_comb begin
    if_req_ready  = grant_if;
    mem_req_ready = grant_mem;
    ram_en        = access & ~sel_wen;
    ram_wen       = access & sel_wen;
    ram_ridx      = access ? idx : 64'd0;
    ram_widx      = access ? idx : 64'd0;
    ram_wdata     = ram_wen ? mem_req_wdata : '0;
    ram_wmask     = ram_wen ? mem_req_wmask : '0;
    rsp_data_d    = ram_en ? ram_rdata : '0;
  end

  // State records the owner of the response in flight; it directly drives rsp_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      if_data_q    <= '0;
      if_err_q     <= 1'b0;
      mem_data_q   <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      if (grant_if)       state_q <= StRspIf;
      else if (grant_mem) state_q <= StRspMem;
      else                state_q <= StIdle;

      if (grant_if) begin
        if_data_q <= rsp_data_d;
        if_err_q  <= ~in_range;
      end
      if (grant_mem) begin
        mem_data_q <= rsp_data_d;
        mem_err_q  <= ~in_range;
      end

      if (grant_if || !if_req_valid) begin
        starve_cnt_q <= '0;
      end else if (grant_mem && starve_cnt_q != CntW'(STARVE_MAX)) begin
        starve_cnt_q <= starve_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    if_rsp_valid  = (state_q == StRspIf);
    mem_rsp_valid = (state_q == StRspMem);
    if_rsp_data   = if_rsp_valid ? if_data_q : '0;
    if_rsp_err    = if_rsp_valid & if_err_q;
    mem_rsp_data  = mem_rsp_valid ? mem_data_q : '0;
    mem_rsp_err   = mem_rsp_valid & mem_err_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a combinational RAM model returning {CAFEF00D, idx}.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
  logic [63:0] if_req_addr, if_rsp_data;
  logic        mem_req_valid, mem_req_wen, mem_req_ready, mem_rsp_valid, mem_rsp_err;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_req_wmask, mem_rsp_data;
  logic        ram_en, ram_wen;
  logic [63:0] ram_ridx, ram_rdata, ram_widx, ram_wdata, ram_wmask;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ram_rdata = ram_en ? {32'hCAFE_F00D, ram_ridx[31:0]} : 64'd0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .ram_en(ram_en), .ram_ridx(ram_ridx), .ram_rdata(ram_rdata),
    .ram_wen(ram_wen), .ram_widx(ram_widx), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask)
  );

  task automatic idle_inputs();
    if_req_valid = 1'b0; if_req_addr = 64'd0;
    mem_req_valid = 1'b0; mem_req_wen = 1'b0; mem_req_addr = 64'd0;
    mem_req_wdata = 64'd0; mem_req_wmask = 64'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0010;
    #12;
    checks++;
    if (if_req_ready !== 1'b0) begin failures++;
      $display("FAIL reset_if_ready got=%b want=0", if_req_ready); end
    checks++;
    if ({ram_en, ram_wen, ram_ridx, ram_widx} !== 130'd0) begin failures++;
      $display("FAIL reset_ram got en=%b wen=%b ridx=%h widx=%h want 0", ram_en, ram_wen,
               ram_ridx, ram_widx); end
    checks++;
    if ({if_rsp_valid, mem_rsp_valid, if_rsp_data, mem_rsp_data} !== 130'd0) begin failures++;
      $display("FAIL reset_rsp got ifv=%b memv=%b want 0", if_rsp_valid, mem_rsp_valid); end
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_if_read();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0010;
    #1;
    checks++;
    if ({if_req_ready, mem_req_ready, ram_en, ram_wen} !== 4'b1010) begin failures++;
      $display("FAIL if_read_grant got rdy=%b mrdy=%b en=%b wen=%b want 1,0,1,0",
               if_req_ready, mem_req_ready, ram_en, ram_wen); end
    checks++;
    if (ram_ridx !== 64'd2) begin failures++;
      $display("FAIL if_read_ridx got=%h want=2", ram_ridx); end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    checks++;
    if (if_rsp_valid !== 1'b1 || if_rsp_data !== 64'hCAFE_F00D_0000_0002 || if_rsp_err !== 1'b0)
    begin failures++;
      $display("FAIL if_read_rsp got v=%b d=%h e=%b want 1 cafef00d00000002 0",
               if_rsp_valid, if_rsp_data, if_rsp_err); end
    @(posedge clk); #1;
    checks++;
    if (if_rsp_valid !== 1'b0 || mem_rsp_valid !== 1'b0) begin failures++;
      $display("FAIL if_read_pulse got ifv=%b memv=%b want 0 0", if_rsp_valid, mem_rsp_valid); end
  endtask

  task automatic test_mem_priority();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0018;
    mem_req_valid = 1'b1; mem_req_wen = 1'b1; mem_req_addr = 64'h8000_0008;
    mem_req_wdata = 64'hDEAD; mem_req_wmask = '1;
    #1;
    checks++;
    if ({mem_req_ready, if_req_ready, ram_wen, ram_en} !== 4'b1010) begin failures++;
      $display("FAIL prio_grant got mrdy=%b irdy=%b wen=%b en=%b want 1,0,1,0",
               mem_req_ready, if_req_ready, ram_wen, ram_en); end
    checks++;
    if (ram_widx !== 64'd1 || ram_wdata !== 64'hDEAD || ram_wmask !== '1) begin failures++;
      $display("FAIL prio_write got widx=%h wdata=%h wmask=%h want 1 dead ffff..",
               ram_widx, ram_wdata, ram_wmask); end
    @(posedge clk); #1;
    mem_req_valid = 1'b0; mem_req_wen = 1'b0;
    checks++;
    if (mem_rsp_valid !== 1'b1 || mem_rsp_data !== 64'd0 || if_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL prio_store_rsp got mv=%b md=%h iv=%b want 1 0 0",
               mem_rsp_valid, mem_rsp_data, if_rsp_valid); end
    #1;
    checks++;
    if (if_req_ready !== 1'b1 || ram_ridx !== 64'd3) begin failures++;
      $display("FAIL prio_if_next got rdy=%b ridx=%h want 1 3", if_req_ready, ram_ridx); end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    checks++;
    if (if_rsp_valid !== 1'b1 || if_rsp_data !== 64'hCAFE_F00D_0000_0003 || mem_rsp_valid !== 0)
    begin failures++;
      $display("FAIL prio_if_rsp got iv=%b d=%h mv=%b want 1 cafef00d00000003 0",
               if_rsp_valid, if_rsp_data, mem_rsp_valid); end
  endtask

  task automatic test_starvation();
    logic exp_if [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    mem_req_valid = 1'b1; mem_req_wen = 1'b0; mem_req_addr = 64'h8000_0020;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0028;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++;
      if (if_req_ready !== exp_if[i] || mem_req_ready !== !exp_if[i]) begin failures++;
        $display("FAIL starve_grant[%0d] got irdy=%b mrdy=%b want %b %b", i, if_req_ready,
                 mem_req_ready, exp_if[i], !exp_if[i]); end
      @(posedge clk); #1;
      checks++;
      if (if_rsp_valid !== exp_if[i] || mem_rsp_valid !== !exp_if[i]) begin failures++;
        $display("FAIL starve_rsp[%0d] got iv=%b mv=%b want %b %b", i, if_rsp_valid,
                 mem_rsp_valid, exp_if[i], !exp_if[i]); end
      if (exp_if[i]) begin
        if_req_valid = 1'b0;
        checks++;
        if (if_rsp_data !== 64'hCAFE_F00D_0000_0005) begin failures++;
          $display("FAIL starve_if_data got=%h want=cafef00d00000005", if_rsp_data); end
      end
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_range();
    mem_req_valid = 1'b1; mem_req_addr = 64'h7FFF_FFF8;
    #1;
    checks++;
    if (mem_req_ready !== 1'b1 || ram_en !== 1'b0 || ram_wen !== 1'b0) begin failures++;
      $display("FAIL range_low_ram got rdy=%b en=%b wen=%b want 1 0 0",
               mem_req_ready, ram_en, ram_wen); end
    @(posedge clk); #1;
    idle_inputs();
    checks++;
    if (mem_rsp_valid !== 1'b1 || mem_rsp_err !== 1'b1 || mem_rsp_data !== 64'd0) begin
      failures++;
      $display("FAIL range_low_rsp got v=%b e=%b d=%h want 1 1 0",
               mem_rsp_valid, mem_rsp_err, mem_rsp_data); end
    if_req_valid = 1'b1; if_req_addr = 64'h8800_0000;
    #1;
    checks++;
    if (if_req_ready !== 1'b1 || ram_en !== 1'b0) begin failures++;
      $display("FAIL range_high_ram got rdy=%b en=%b want 1 0", if_req_ready, ram_en); end
    @(posedge clk); #1;
    checks++;
    if (if_rsp_valid !== 1'b1 || if_rsp_err !== 1'b1 || if_rsp_data !== 64'd0) begin failures++;
      $display("FAIL range_high_rsp got v=%b e=%b d=%h want 1 1 0",
               if_rsp_valid, if_rsp_err, if_rsp_data); end
    if_req_addr = 64'h87FF_FFFF;
    #1;
    checks++;
    if (ram_en !== 1'b1 || ram_ridx !== 64'h0FF_FFFF) begin failures++;
      $display("FAIL range_top_word got en=%b ridx=%h want 1 00ffffff", ram_en, ram_ridx); end
    @(posedge clk); #1;
    idle_inputs();
    checks++;
    if (if_rsp_err !== 1'b0 || if_rsp_data !== 64'hCAFE_F00D_00FF_FFFF) begin failures++;
      $display("FAIL range_top_rsp got e=%b d=%h want 0 cafef00d00ffffff",
               if_rsp_err, if_rsp_data); end
  endtask

  task automatic test_back_to_back();
    logic        is_mem [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        is_wr  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] addr   [4] = '{64'h8000_0030, 64'h8000_0038, 64'h8000_0040, 64'h8000_0048};
    logic [63:0] exp_d  [4] = '{64'hCAFE_F00D_0000_0006, 64'hCAFE_F00D_0000_0007, 64'd0,
                               64'hCAFE_F00D_0000_0009};
    for (int i = 0; i < 4; i++) begin
      mem_req_valid = is_mem[i]; mem_req_wen = is_wr[i]; mem_req_addr = addr[i];
      mem_req_wmask = '1; mem_req_wdata = 64'h1234;
      if_req_valid = !is_mem[i]; if_req_addr = addr[i];
      @(posedge clk); #1;
      checks++;
      if (mem_rsp_valid !== is_mem[i] || if_rsp_valid !== !is_mem[i]) begin failures++;
        $display("FAIL b2b_owner[%0d] got mv=%b iv=%b want %b %b", i, mem_rsp_valid,
                 if_rsp_valid, is_mem[i], !is_mem[i]); end
      checks++;
      if ((is_mem[i] ? mem_rsp_data : if_rsp_data) !== exp_d[i]) begin failures++;
        $display("FAIL b2b_data[%0d] got=%h want=%h", i,
                 is_mem[i] ? mem_rsp_data : if_rsp_data, exp_d[i]); end
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0010;
    @(posedge clk); #1;
    checks++;
    if (if_rsp_valid !== 1'b1) begin failures++;
      $display("FAIL mid_pending got=%b want=1", if_rsp_valid); end
    reset = 1'b0;
    #1;
    checks++;
    if ({if_rsp_valid, if_req_ready, ram_en, if_rsp_data, ram_ridx} !== 131'd0) begin
      failures++;
      $display("FAIL mid_reset_outs got iv=%b rdy=%b en=%b d=%h ridx=%h want 0",
               if_rsp_valid, if_req_ready, ram_en, if_rsp_data, ram_ridx); end
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (if_rsp_valid !== 1'b0 || mem_rsp_valid !== 1'b0) begin failures++;
        $display("FAIL mid_after[%0d] got iv=%b mv=%b want 0 0", i, if_rsp_valid,
                 mem_rsp_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_mem_priority();
    test_starvation();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
